// File: rtl/memory_bus_responder.sv
// Single-word bus responder in front of a synchronous single-port RAM.
// Adds WAIT_STATES cycles before capture and reports range/protocol errors as sticky flags.
module memory_bus_responder #(
    parameter int unsigned ADDR_BITS   = 14,
    parameter logic [31:0] BASE        = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          bus_addr,
    input  logic [31:0]          bus_data,
    input  logic                 bus_we,
    input  logic                 bus_start,
    output logic [31:0]          bus_q,
    output logic                 bus_done,
    output logic                 bus_ready,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [31:0]          mem_d,
    output logic                 mem_en,
    output logic                 mem_we,
    input  logic [31:0]          mem_q,
    output logic [1:0]           err,
    input  logic                 err_clr
);

    typedef enum logic [2:0] {StIdle, StAccess, StWait, StCapture, StDone} state_e;

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [31:0]          data_q, data_d;
    logic                 we_q, we_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [31:0]          q_q, q_d;
    logic [1:0]           err_q, err_d;
    logic [1:0]           err_set;
    logic [31:0]          off;
    logic                 in_range;

    // Wrapping subtraction; the explicit >= check rejects addresses below BASE.
    assign off      = bus_addr - BASE;
    assign in_range = (bus_addr >= BASE) && ((off >> ADDR_BITS) == 32'd0);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        err_set = 2'b00;
        case (state_q)
            StIdle: begin
                if (bus_start) begin
                    data_d = bus_data;
                    we_d   = bus_we;
                    if (in_range) begin
                        addr_d  = off[ADDR_BITS-1:0];
                        state_d = StAccess;
                    end else begin
                        q_d        = 32'd0;
                        err_set[0] = 1'b1;
                        state_d    = StDone;
                    end
                end
            end
            StAccess: begin
                cnt_d   = 4'(WAIT_STATES);
                state_d = (WAIT_STATES > 0) ? StWait : StCapture;
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = StCapture;
            end
            StCapture: begin
                q_d     = we_q ? 32'd0 : mem_q;
                state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (bus_start && (state_q != StIdle)) err_set[1] = 1'b1;
        // A new error beats a simultaneous clear for that bit only.
        err_d = (err_clr ? 2'b00 : err_q) | err_set;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            data_q  <= 32'd0;
            we_q    <= 1'b0;
            cnt_q   <= 4'd0;
            q_q     <= 32'd0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            err_q   <= err_d;
        end
    end

    assign bus_ready = (state_q == StIdle);
    assign bus_done  = (state_q == StDone);
    assign bus_q     = bus_done ? q_q : 32'd0;
    assign mem_en    = (state_q == StAccess);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_d     = data_q;
    assign err       = err_q;

endmodule

// File: doc/memory_bus_responder.md
# memory_bus_responder

Memory-side responder for the CPU data bus. Accepts single-word transactions started by a one-cycle `bus_start` pulse from the CPU data-memory initiator. Performs each transaction against a synchronous single-port RAM with a configurable number of wait states, then returns read data with a one-cycle `bus_done` pulse. Reports out-of-range accesses and protocol violations through sticky error flags.

## Interface
- `ADDR_BITS`, default 14: word-address width of the backing RAM; the RAM holds 2^ADDR_BITS 32-bit words.
- `BASE`, default 32'h0000_0000: first bus (word) address mapped to RAM word 0.
- `WAIT_STATES`, default 0: extra cycles inserted between the RAM access and the data capture; legal range 0–15.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `bus_addr`  in  32  word address; sampled only on an accepted `bus_start`.
- `bus_data`  in  32  write data; sampled with `bus_addr`.
- `bus_we`  in  1  1 = write, 0 = read; sampled with `bus_addr`.
- `bus_start`  in  1  one-cycle transaction request.
- `bus_q`  out  32  read data; valid only while `bus_done` = 1.
- `bus_done`  out  1  one-cycle completion pulse.
- `bus_ready`  out  1  1 when in IDLE and able to accept `bus_start`.
- `mem_addr`  out  ADDR_BITS  RAM word address.
- `mem_d`  out  32  RAM write data.
- `mem_en`  out  1  RAM enable; one-cycle pulse per access.
- `mem_we`  out  1  RAM write enable; qualified by `mem_en`.
- `mem_q`  in  32  RAM read data, registered by the RAM; valid the cycle after `mem_en` and held until the next `mem_en`.
- `err`  out  2  sticky flags: bit0 = out-of-range access, bit1 = `bus_start` while not ready.
- `err_clr`  in  1  clears `err` synchronously.

## Operation
- States: IDLE, ACCESS, WAIT, CAPTURE, DONE. All outputs are registered or decoded from the state register only.
- IDLE: `bus_ready` = 1. On `bus_start`, latch addr, data and we. Compute `off = bus_addr − BASE` in 32-bit arithmetic.
  - In range when `bus_addr ≥ BASE` and `off < 2^ADDR_BITS` (unsigned). In range → go to ACCESS with `mem_addr = off[ADDR_BITS-1:0]`.
  - Out of range → go directly to DONE with `bus_q` = 0 and set `err[0]`. The RAM is never touched.
- ACCESS: `mem_en` = 1, `mem_we` = latched we, `mem_d` = latched data. Load the wait counter with `WAIT_STATES`. Go to WAIT if `WAIT_STATES` > 0, else go to CAPTURE.
- WAIT: decrement the counter each cycle; go to CAPTURE when the counter reaches 1.
- CAPTURE: register `bus_q` ← `mem_q` for reads, `bus_q` ← 0 for writes. Go to DONE.
- DONE: `bus_done` = 1 for exactly one cycle, then return to IDLE. Outside DONE, `bus_q` is driven 0.
- `bus_start` seen while `bus_ready` = 0: the request is ignored, `err[1]` is set, and the current transaction proceeds unchanged.
- `err_clr` and a new error in the same cycle: set wins for that bit; the other bit clears.
- Address, data and we are held internally, so initiator inputs may change after the start cycle.

## Timing
- Reset asserted: state returns to IDLE immediately (asynchronous). Resulting values: `bus_ready` = 1, `bus_done` = 0, `bus_q` = 0, `mem_en` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_d` = 0, `err` = 0.
- Reset mid-transaction: the transaction is aborted with no `bus_done`. If reset falls during ACCESS, `mem_en`/`mem_we` drop at once; whether a write lands in the RAM is undefined.
- In-range latency, with `bus_start` in cycle 0:
  - ACCESS in cycle 1.
  - WAIT in cycles 2 .. 1+W.
  - CAPTURE in cycle 2+W.
  - `bus_done` in cycle 3+W.
  - `bus_ready` = 1 again in cycle 4+W.
- Out-of-range latency: `bus_done` in cycle 1; ready again in cycle 2.
- Maximum throughput: one transaction per 4+W cycles.
- `bus_done` is never asserted in two consecutive cycles.

## Test plan
- Reset: hold reset low, then release → all outputs at the reset values above, `bus_ready` = 1.
- Read, W=0: preload RAM word 5 = 32'hDEADBEEF; pulse `bus_start` with addr 5, we 0 in cycle 0 → `mem_en` in cycle 1, `bus_done` = 1 and `bus_q` = 32'hDEADBEEF in cycle 3, `bus_ready` = 1 in cycle 4.
- Write then read, W=2, BASE=32'h100: write 32'h12345678 to addr 32'h103 → RAM word 3 written, `bus_done` in cycle 5 with `bus_q` = 0. Then read addr 32'h103 → `bus_q` = 32'h12345678 at `bus_done`.
- Out of range, BASE=32'h100, ADDR_BITS=14: read addr 32'hFF → `bus_done` in cycle 1, `bus_q` = 0, `err` = 2'b01, `mem_en` never asserted. Repeat with addr 32'h4100 → same result. Pulse `err_clr` → `err` = 0.
- Start while busy: second `bus_start` (addr 7) in cycle 2 of a read of addr 5 → only addr 5 is accessed, a single `bus_done`, `err[1]` = 1.
- Reset mid-transaction: reset low during WAIT (W=3) → no `bus_done`; IDLE and `bus_ready` = 1 immediately. A following read completes normally.
